sargantana_itag_ctrl: RTL

//  Access sequencer for the I-cache tag/valid array (N-way tag SRAM + valid-bit vectors).

---
 rtl/sargantana_itag_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sargantana_itag_ctrl.sv
// sargantana_itag_ctrl: I-cache tag/valid array access sequencer; ITAG_CTRL_FLUSH_SWEEP_EN selects the per-index flush sweep
module sargantana_itag_ctrl #(
    parameter int N_WAY = 4,
    parameter int TAG_W = 20,
    parameter int IDX_W = 6
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   lk_valid_i,
    input  logic [IDX_W-1:0]       lk_idx_i,
    input  logic [TAG_W-1:0]       lk_tag_i,
    output logic                   lk_ready_o,
    output logic                   lk_rvalid_o,
    output logic                   lk_hit_o,
    output logic [N_WAY-1:0]       lk_way_o,
    input  logic                   rf_valid_i,
    input  logic [IDX_W-1:0]       rf_idx_i,
    input  logic [TAG_W-1:0]       rf_tag_i,
    output logic                   rf_ready_o,
    output logic [N_WAY-1:0]       rf_way_o,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   flush_done_o,
    output logic [N_WAY-1:0]       mem_req_o,
    output logic                   mem_we_o,
    output logic                   mem_vbit_o,
    output logic                   mem_flush_o,
    output logic [IDX_W-1:0]       mem_addr_o,
    output logic [TAG_W-1:0]       mem_data_o,
    input  logic [N_WAY*TAG_W-1:0] mem_tag_i,
    input  logic [N_WAY-1:0]       mem_vbit_i
);
    localparam int RR_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, SWEEP} state_t;

    state_t            state;
    logic [RR_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]  tag_q;
    logic              rvalid_q;
    logic              open_slot;
    logic              rf_gnt;
    logic              lk_gnt;
    logic              sweep_op;
    logic [IDX_W-1:0]  sweep_addr;
    logic [N_WAY-1:0]  victim;
    logic [N_WAY-1:0]  hit_vec;

    // Requests are only granted in IDLE with no flush arriving; reset keeps every grant low
    assign open_slot = rstn_i && state == IDLE && !flush_i;
    assign rf_gnt    = open_slot && rf_valid_i;
    assign lk_gnt    = open_slot && lk_valid_i && !rf_valid_i;
    assign victim    = N_WAY'(1) << rr_ptr;

`ifdef ITAG_CTRL_FLUSH_SWEEP_EN
    logic [IDX_W-1:0] sweep_idx;

    assign sweep_op     = state == SWEEP;
    assign sweep_addr   = sweep_idx;
    assign busy_o       = sweep_op;
    assign flush_done_o = sweep_op && sweep_idx == '1 && !flush_i;
    assign mem_flush_o  = 1'b0;

    // Sweep index walks every set once; a new flush restarts it from zero
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            sweep_idx <= '0;
        else
            sweep_idx <= flush_i ? '0 : sweep_op ? sweep_idx + 1'b1 : sweep_idx;
    end
`else
    assign sweep_op     = 1'b0;
    assign sweep_addr   = '0;
    assign busy_o       = 1'b0;
    assign flush_done_o = state == FLUSH;
    assign mem_flush_o  = state == FLUSH;
`endif

    // Control FSM, victim pointer and lookup pipeline register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            tag_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= lk_gnt;
            if (lk_gnt)
                tag_q <= lk_tag_i;
            if (rf_gnt)
                rr_ptr <= (rr_ptr == RR_W'(N_WAY-1)) ? '0 : rr_ptr + 1'b1;
`ifdef ITAG_CTRL_FLUSH_SWEEP_EN
            if (flush_i)
                state <= SWEEP;
            else if (sweep_op && sweep_addr == '1)
                state <= IDLE;
`else
            state <= flush_i ? FLUSH : IDLE;
`endif
        end
    end

    // Single array port: sweep write > refill write > lookup read
    always_comb begin
        mem_req_o  = sweep_op ? '1 : rf_gnt ? victim : lk_gnt ? '1 : '0;
        mem_we_o   = sweep_op || rf_gnt;
        mem_vbit_o = !sweep_op && rf_gnt;
        mem_addr_o = sweep_op ? sweep_addr : rf_gnt ? rf_idx_i : lk_gnt ? lk_idx_i : '0;
        mem_data_o = (!sweep_op && rf_gnt) ? rf_tag_i : '0;
    end

    assign lk_ready_o = lk_gnt;
    assign rf_ready_o = rf_gnt;
    assign rf_way_o   = rf_gnt ? victim : '0;

    for (genvar w = 0; w < N_WAY; w++) begin : g_cmp
        assign hit_vec[w] = rvalid_q && mem_vbit_i[w] && mem_tag_i[w*TAG_W +: TAG_W] == tag_q;
    end

    assign lk_rvalid_o = rvalid_q;
    assign lk_way_o    = hit_vec;
    assign lk_hit_o    = |hit_vec;

    a_one_hit : assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(hit_vec));

endmodule
